// File: rtl/smg_scan_decoder_if.sv
// smg_scan_decoder_if
// Bundles the display pins watched by the scan decoder and the decoded frame it
// publishes.
//   SMG_Data   [7:0] segment drive, active-low ([7]=DP, [6:0]=g..a)
//   Scan_Sig   [1:0] digit select, active-low ([1]=Tens, [0]=Ones)
//   Ten_Data   [3:0] decoded Tens digit (0-9, F=blank, E=invalid)
//   One_Data   [3:0] decoded Ones digit (same coding)
//   Dp_Data    [1:0] DP lit per digit ([1]=Tens, [0]=Ones)
//   Frame_Done       one-cycle pulse when the frame outputs update
//   Frame_Err        current frame holds an invalid digit
//   Sel_Err          pulse per cycle of a conflicting digit select
//   Stale            no frame completed within the timeout window
// master = display-side driver and frame consumer, slave = the decoder.
interface smg_scan_decoder_if;
  logic [7:0] SMG_Data;
  logic [1:0] Scan_Sig;
  logic [3:0] Ten_Data;
  logic [3:0] One_Data;
  logic [1:0] Dp_Data;
  logic       Frame_Done;
  logic       Frame_Err;
  logic       Sel_Err;
  logic       Stale;

  modport master (
    output SMG_Data, Scan_Sig,
    input  Ten_Data, One_Data, Dp_Data, Frame_Done, Frame_Err, Sel_Err, Stale
  );

  modport slave (
    input  SMG_Data, Scan_Sig,
    output Ten_Data, One_Data, Dp_Data, Frame_Done, Frame_Err, Sel_Err, Stale
  );
endinterface

// File: rtl/smg_scan_decoder.sv
// smg_scan_decoder
// Loopback monitor on a two-digit multiplexed seven-segment display. Samples the
// active-low segment bus and digit selects, waits for each digit to hold steady
// for SETTLE_CYC equal samples, decodes the pattern back to a digit code and
// publishes a double-buffered Tens/Ones frame with error and staleness flags.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous active-high reset
//   bus  smg_scan_decoder_if.slave (display pins in, decoded frame out)
// Parameters:
//   SETTLE_CYC   equal consecutive samples needed before a capture (>=1)
//   TIMEOUT_CYC  cycles without a frame before Stale asserts (>=2)
module smg_scan_decoder #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  smg_scan_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYC);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  logic [9:0]       r1_q, r1_d, r2_q, r2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             got_ten_q, got_ten_d, got_one_q, got_one_d;
  logic [3:0]       sh_ten_code_q, sh_ten_code_d, sh_one_code_q, sh_one_code_d;
  logic             sh_ten_dp_q, sh_ten_dp_d, sh_one_dp_q, sh_one_dp_d;
  logic [3:0]       ten_q, ten_d, one_q, one_d;
  logic [1:0]       dp_q, dp_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             sel_err_q, sel_err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic [1:0] sel;
  logic       sel_valid, sel_tens, same, capture, transfer;
  logic [3:0] code;
  logic       dp_lit;

  // Select decoding on the first input register; exactly one line low is a
  // valid digit, 2'b11 is blanking and 2'b00 a conflict.
  always_comb begin
    r1_d      = {bus.Scan_Sig, bus.SMG_Data};
    r2_d      = r1_q;
    sel       = r1_q[9:8];
    sel_valid = (sel == 2'b01) || (sel == 2'b10);
    sel_tens  = (sel == 2'b01);
    same      = (r1_q == r2_q);
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // Segment pattern back to digit code; DP is decoded separately.
  always_comb begin
    dp_lit = ~r1_q[7];
    case (r1_q[6:0])
      7'h40:   code = 4'd0;
      7'h79:   code = 4'd1;
      7'h24:   code = 4'd2;
      7'h30:   code = 4'd3;
      7'h19:   code = 4'd4;
      7'h12:   code = 4'd5;
      7'h02:   code = 4'd6;
      7'h78:   code = 4'd7;
      7'h00:   code = 4'd8;
      7'h10:   code = 4'd9;
      7'h7F:   code = 4'hF;
      default: code = 4'hE;
    endcase
  end

  // Stability FSM: any change between r1 and r2 restarts the count, and a
  // digit is captured once it has matched for SETTLE_CYC edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!sel_valid) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
        ST_COUNT: begin
          if (!same) begin
            cnt_d = '0;
          end else if (cnt_inc == SETTLE_VAL) begin
            capture = 1'b1;
            state_d = ST_HELD;
            cnt_d   = cnt_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: begin
          if (!same) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Shadow capture and frame transfer. The got bits are cleared by a transfer
  // but a capture on that same edge re-arms its bit for the next frame.
  always_comb begin
    transfer      = got_ten_q & got_one_q;
    got_ten_d     = (got_ten_q & ~transfer) | (capture & sel_tens);
    got_one_d     = (got_one_q & ~transfer) | (capture & ~sel_tens);
    sh_ten_code_d = sh_ten_code_q;
    sh_ten_dp_d   = sh_ten_dp_q;
    sh_one_code_d = sh_one_code_q;
    sh_one_dp_d   = sh_one_dp_q;
    if (capture && sel_tens) begin
      sh_ten_code_d = code;
      sh_ten_dp_d   = dp_lit;
    end
    if (capture && !sel_tens) begin
      sh_one_code_d = code;
      sh_one_dp_d   = dp_lit;
    end
    ten_d        = ten_q;
    one_d        = one_q;
    dp_d         = dp_q;
    frame_err_d  = frame_err_q;
    frame_done_d = transfer;
    if (transfer) begin
      ten_d       = sh_ten_code_q;
      one_d       = sh_one_code_q;
      dp_d        = {sh_ten_dp_q, sh_one_dp_q};
      frame_err_d = (sh_ten_code_q == 4'hE) || (sh_one_code_q == 4'hE);
    end
    sel_err_d = (sel == 2'b00);
    // Clearing on the transfer edge lets Stale drop together with Frame_Done.
    if (transfer) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_q          <= '1;
      r2_q          <= '1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      got_ten_q     <= 1'b0;
      got_one_q     <= 1'b0;
      sh_ten_code_q <= 4'hF;
      sh_ten_dp_q   <= 1'b0;
      sh_one_code_q <= 4'hF;
      sh_one_dp_q   <= 1'b0;
      ten_q         <= 4'hF;
      one_q         <= 4'hF;
      dp_q          <= 2'b00;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      sel_err_q     <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      r1_q          <= r1_d;
      r2_q          <= r2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      got_ten_q     <= got_ten_d;
      got_one_q     <= got_one_d;
      sh_ten_code_q <= sh_ten_code_d;
      sh_ten_dp_q   <= sh_ten_dp_d;
      sh_one_code_q <= sh_one_code_d;
      sh_one_dp_q   <= sh_one_dp_d;
      ten_q         <= ten_d;
      one_q         <= one_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      sel_err_q     <= sel_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign bus.Ten_Data   = ten_q;
  assign bus.One_Data   = one_q;
  assign bus.Dp_Data    = dp_q;
  assign bus.Frame_Done = frame_done_q;
  assign bus.Frame_Err  = frame_err_q;
  assign bus.Sel_Err    = sel_err_q;
  assign bus.Stale      = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_smg_scan_decoder.sv
// tb_smg_scan_decoder
// Directed testbench for smg_scan_decoder with SETTLE_CYC=4, TIMEOUT_CYC=20.
// Each scenario task drives the display pins and compares the decoded frame
// against hand-computed values.
module tb_smg_scan_decoder;

  logic CLK;
  logic RST;
  int   checks;
  int   fails;
  int   done_count;
  int   sel_err_count;

  smg_scan_decoder_if bus ();

  smg_scan_decoder #(
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (bus.Frame_Done === 1'b1) done_count++;
    if (bus.Sel_Err === 1'b1) sel_err_count++;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic hold(input logic [1:0] sel, input logic [7:0] seg, input int n);
    bus.Scan_Sig = sel;
    bus.SMG_Data = seg;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Scan_Sig = 2'($urandom);
      bus.SMG_Data = 8'($urandom);
      tick();
      checks++;
      if (bus.Frame_Done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_done: got %b expected 0", bus.Frame_Done);
      end
    end
    bus.Scan_Sig = 2'b11;
    bus.SMG_Data = 8'hFF;
    RST = 1'b0;
    tick();
    checks++;
    if ({bus.Ten_Data, bus.One_Data, bus.Dp_Data} !== {4'hF, 4'hF, 2'b00}) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h/%h/%b expected F/F/00",
               bus.Ten_Data, bus.One_Data, bus.Dp_Data);
    end
    checks++;
    if ({bus.Frame_Done, bus.Frame_Err, bus.Sel_Err, bus.Stale} !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {bus.Frame_Done, bus.Frame_Err, bus.Sel_Err, bus.Stale});
    end
  endtask

  task automatic test_clean_frame();
    int base;
    base = done_count;
    hold(2'b01, 8'hA4, 8);
    checks++;
    if (done_count - base !== 0) begin
      fails++;
      $display("[TB] FAIL clean_tens_only: got %0d frames expected 0", done_count - base);
    end
    bus.Scan_Sig = 2'b10;
    bus.SMG_Data = 8'h90;
    // Ones pattern enters r1 at the 1st edge (e0); the frame lands on e6.
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.Frame_Done !== 1'(k == 7)) begin
        fails++;
        $display("[TB] FAIL clean_done_edge%0d: got %b expected %b",
                 k, bus.Frame_Done, 1'(k == 7));
      end
    end
    checks++;
    if ({bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err} !== {4'h2, 4'h9, 2'b00, 1'b0}) begin
      fails++;
      $display("[TB] FAIL clean_frame: got %h/%h/%b/%b expected 2/9/00/0",
               bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err);
    end
    checks++;
    if (done_count - base !== 1) begin
      fails++;
      $display("[TB] FAIL clean_count: got %0d frames expected 1", done_count - base);
    end
    hold(2'b11, 8'hFF, 3);
  endtask

  task automatic test_glitch_dp();
    hold(2'b10, 8'hF9, 8);
    bus.Scan_Sig = 2'b01;
    bus.SMG_Data = 8'h40;
    tick();
    tick();
    bus.SMG_Data = 8'hFF;
    tick();
    bus.SMG_Data = 8'h40;
    // Without the glitch the frame would land on e6; the restart moves it to e9.
    for (int j = 3; j <= 11; j++) begin
      tick();
      checks++;
      if (bus.Frame_Done !== 1'(j == 9)) begin
        fails++;
        $display("[TB] FAIL glitch_done_e%0d: got %b expected %b",
                 j, bus.Frame_Done, 1'(j == 9));
      end
    end
    checks++;
    if ({bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err} !== {4'h0, 4'h1, 2'b10, 1'b0}) begin
      fails++;
      $display("[TB] FAIL glitch_frame: got %h/%h/%b/%b expected 0/1/10/0",
               bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err);
    end
    hold(2'b11, 8'hFF, 3);
  endtask

  task automatic test_invalid_conflict();
    int dbase;
    int sbase;
    hold(2'b01, 8'h99, 8);
    dbase = done_count;
    sbase = sel_err_count;
    bus.Scan_Sig = 2'b00;
    bus.SMG_Data = 8'h92;
    tick();
    checks++;
    if (bus.Sel_Err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sel_err_e0: got %b expected 0", bus.Sel_Err);
    end
    tick();
    checks++;
    if (bus.Sel_Err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL sel_err_e1: got %b expected 1", bus.Sel_Err);
    end
    tick();
    hold(2'b11, 8'hFF, 3);
    checks++;
    if (sel_err_count - sbase !== 3) begin
      fails++;
      $display("[TB] FAIL sel_err_count: got %0d expected 3", sel_err_count - sbase);
    end
    checks++;
    if (done_count - dbase !== 0) begin
      fails++;
      $display("[TB] FAIL conflict_capture: got %0d frames expected 0", done_count - dbase);
    end
    hold(2'b10, 8'hAA, 8);
    checks++;
    if (done_count - dbase !== 1) begin
      fails++;
      $display("[TB] FAIL invalid_count: got %0d frames expected 1", done_count - dbase);
    end
    checks++;
    if ({bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err} !== {4'h4, 4'hE, 2'b00, 1'b1}) begin
      fails++;
      $display("[TB] FAIL invalid_frame: got %h/%h/%b/%b expected 4/E/00/1",
               bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Err);
    end
    hold(2'b11, 8'hFF, 3);
  endtask

  task automatic test_stale();
    logic found;
    logic prev_stale;
    hold(2'b01, 8'hC0, 8);
    bus.Scan_Sig = 2'b10;
    bus.SMG_Data = 8'h80;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.Frame_Done === 1'b1) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1 || {bus.Ten_Data, bus.One_Data, bus.Frame_Err, bus.Stale} !== {4'h0, 4'h8, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL stale_first_frame: got done=%b %h/%h err=%b stale=%b expected done=1 0/8 err=0 stale=0",
               found, bus.Ten_Data, bus.One_Data, bus.Frame_Err, bus.Stale);
    end
    bus.Scan_Sig = 2'b11;
    bus.SMG_Data = 8'hFF;
    repeat (19) tick();
    checks++;
    if (bus.Stale !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stale_edge19: got %b expected 0", bus.Stale);
    end
    tick();
    checks++;
    if (bus.Stale !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stale_edge20: got %b expected 1", bus.Stale);
    end
    hold(2'b01, 8'hF8, 8);
    checks++;
    if (bus.Stale !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stale_saturate: got %b expected 1", bus.Stale);
    end
    bus.Scan_Sig = 2'b10;
    bus.SMG_Data = 8'h82;
    found = 1'b0;
    prev_stale = bus.Stale;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.Frame_Done === 1'b1) found = 1'b1;
      else prev_stale = bus.Stale;
    end
    checks++;
    if (found !== 1'b1 || prev_stale !== 1'b1 || bus.Stale !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stale_clear: got done=%b before=%b at=%b expected done=1 before=1 at=0",
               found, prev_stale, bus.Stale);
    end
    checks++;
    if ({bus.Ten_Data, bus.One_Data} !== {4'h7, 4'h6}) begin
      fails++;
      $display("[TB] FAIL stale_frame: got %h/%h expected 7/6", bus.Ten_Data, bus.One_Data);
    end
    hold(2'b11, 8'hFF, 3);
  endtask

  task automatic test_reset_mid();
    int dbase;
    hold(2'b01, 8'h92, 8);
    bus.Scan_Sig = 2'b11;
    bus.SMG_Data = 8'hFF;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Done} !== {4'hF, 4'hF, 2'b00, 1'b0}) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: got %h/%h/%b/%b expected F/F/00/0",
               bus.Ten_Data, bus.One_Data, bus.Dp_Data, bus.Frame_Done);
    end
    dbase = done_count;
    hold(2'b10, 8'h99, 10);
    checks++;
    if (done_count - dbase !== 0) begin
      fails++;
      $display("[TB] FAIL midreset_ones_only: got %0d frames expected 0", done_count - dbase);
    end
    hold(2'b01, 8'hB0, 8);
    checks++;
    if (done_count - dbase !== 1) begin
      fails++;
      $display("[TB] FAIL midreset_recapture: got %0d frames expected 1", done_count - dbase);
    end
    checks++;
    if ({bus.Ten_Data, bus.One_Data} !== {4'h3, 4'h4}) begin
      fails++;
      $display("[TB] FAIL midreset_frame: got %h/%h expected 3/4", bus.Ten_Data, bus.One_Data);
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    done_count    = 0;
    sel_err_count = 0;
    RST           = 1'b1;
    bus.Scan_Sig  = 2'b11;
    bus.SMG_Data  = 8'hFF;
    $display("[TB] starting smg_scan_decoder bench");
    test_reset();
    test_clean_frame();
    test_glitch_dp();
    test_invalid_conflict();
    test_stale();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/smg_scan_decoder.md
# smg_scan_decoder

Recovers two-digit BCD values from the multiplexed, active-low drive of a two-digit seven-segment display. This is the inverse of the segment encoder path. It samples the segment bus and digit-select lines, waits for each digit to hold steady, decodes the segment pattern back to a digit code, and publishes a double-buffered Tens/Ones frame with error and staleness flags. It sits on the display pins as a loopback monitor for self-test and board bring-up.

## Interface
- SETTLE_CYC, 4: number of consecutive equal samples required before a digit is captured (≥1).
- TIMEOUT_CYC, 50000: number of cycles without a completed frame before Stale asserts (≥2).
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- SMG_Data  in  8  segment drive, active-low; [7]=DP, [6:0]=g..a.
- Scan_Sig  in  2  digit select, active-low; [1]=Tens, [0]=Ones; 2'b11 = blanked, 2'b00 = conflict.
- Ten_Data  out  4  decoded Tens digit: 0–9, 4'hF = blank, 4'hE = invalid pattern.
- One_Data  out  4  decoded Ones digit, same coding as Ten_Data.
- Dp_Data  out  2  DP state per digit, 1 = lit; [1]=Tens, [0]=Ones.
- Frame_Done  out  1  one-cycle pulse when the outputs above update.
- Frame_Err  out  1  1 if either digit in the current frame decoded as 4'hE.
- Sel_Err  out  1  one-cycle pulse for each cycle the input register holds Scan_Sig=2'b00.
- Stale  out  1  1 when TIMEOUT_CYC cycles have elapsed since the last Frame_Done (or since reset).

## Operation
- Input stage: r1 <= {Scan_Sig, SMG_Data}; r2 <= r1. Both registers reset to all-ones.
- Decode table for r1[6:0] (DP is ignored for decode):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9 (values as full bytes with DP off).
  - 7'h7F→F (blank).
  - Any other pattern → E (invalid).
  - DP lit = ~r1[7].
- Per-digit FSM with states IDLE, COUNT, HELD and a stability counter cnt.
  - IDLE: select is blanked or conflict; cnt=0.
  - Go to COUNT when select is exactly one-hot-low.
  - COUNT: if r1==r2, cnt increments; if r1!=r2, cnt=0 and stay in COUNT.
  - On the edge where cnt reaches SETTLE_CYC: capture {code, DP} into the shadow register of the selected digit, set its got bit, go to HELD.
  - HELD: no recapture. Any r1!=r2 → COUNT with cnt=0.
  - Blank or conflict select in any state → IDLE.
- A recapture of the same digit before the other digit arrives overwrites its shadow register (latest value wins).
- Frame transfer happens on the edge after both got bits are set:
  - Shadows copy to Ten_Data/One_Data/Dp_Data.
  - Frame_Err is set to (shadow code == E for either digit).
  - Frame_Done pulses.
  - Both got bits clear.
  - A capture landing on the transfer edge sets its got bit for the next frame; that capture is not lost.
- Timeout counter: clears on Frame_Done, otherwise increments and saturates at TIMEOUT_CYC. Stale = (counter == TIMEOUT_CYC).
- Reset values: Ten_Data=One_Data=4'hF, Dp_Data=2'b00, Frame_Done=0, Frame_Err=0, Sel_Err=0, Stale=0. FSM=IDLE, cnt=0, got bits=0, shadows={4'hF,0}, timeout counter=0.
- RST asserted mid-count or mid-frame discards all partial captures. The next frame requires both digits to be captured again.

## Timing
- The input pair is applied before edge e0 and held. r1 is valid after e0, r2 after e1. cnt=1 at e2, and capture occurs at edge e(SETTLE_CYC+1).
- If that capture completes a frame, outputs and Frame_Done are visible after edge e(SETTLE_CYC+2). Latency is SETTLE_CYC+2 edges from a stable input.
- A glitch of one cycle or more during COUNT restarts the count from 0 at the edge after the glitch enters r1.
- Sel_Err is asserted on the edge after the conflict value enters r1.
- Stale asserts on the TIMEOUT_CYC-th edge after reset or after the last Frame_Done. It deasserts on the same edge that Frame_Done asserts.

## Test plan
- Reset: hold RST for 3 cycles with random inputs → all outputs at reset values; no Frame_Done.
- Clean frame (SETTLE_CYC=4): Scan_Sig=2'b01 with SMG_Data=8'hA4 for 8 cycles, then 2'b10 with 8'h90 for 8 cycles → Frame_Done once, Ten_Data=2, One_Data=9, Frame_Err=0. The pulse occurs exactly 6 edges after the Ones pattern is applied.
- Glitch and DP: during the Tens hold, insert 1 cycle of 8'hFF → capture delayed by the restart. Then 8'h40 → Ten_Data=0, Dp_Data[1]=1.
- Invalid pattern and conflict: Ones=8'hAA → One_Data=4'hE, Frame_Err=1. Scan_Sig=2'b00 for 3 cycles → 3 Sel_Err pulses, no capture.
- Staleness: with TIMEOUT_CYC=20 and no frames after a completed frame → Stale=1 at edge 20. The next Frame_Done clears it on the same edge.
- Reset mid-operation: after a Tens capture, pulse RST, then complete only the Ones digit → no Frame_Done until Tens is recaptured.
